// File: rtl/sampler_dma_pkg.sv
// Shared types and constants for the sampler DMA fetch sequencer.
// Control word layout: [31]=run, [30]=loop, [23:0]=length in words.
package sampler_dma_pkg;

    localparam int RUN_BIT  = 31;
    localparam int LOOP_BIT = 30;
    localparam int LEN_MSB  = 23;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ADDR,
        DATA,
        OUT
    } fetch_state_t;

    typedef struct packed {
        logic [LEN_MSB:0] offset;
        logic             run_q;
        logic             done;
    } voice_ctx_t;

    // Byte address of a word offset; the sum wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [LEN_MSB:0] offset);
        return base + {6'd0, offset, 2'b00};
    endfunction

endpackage

// File: rtl/sampler_dma_voice_ctx.sv
// Per-voice playback context: run edge detect, word offset counter and sticky done flag.
// Loop wrap at end of sample exists only when SAMPLER_DMA_LOOP_EN is defined.
module sampler_dma_voice_ctx
    import sampler_dma_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             loop,
    input  logic [LEN_MSB:0] length,
    input  logic             advance,
    input  logic             mark_done,
    output logic [LEN_MSB:0] offset,
    output logic             done,
    output logic             active
);

    voice_ctx_t       ctx_q;
    voice_ctx_t       ctx_d;
    logic [LEN_MSB:0] offset_inc;
    logic             wrap_en;

`ifdef SAMPLER_DMA_LOOP_EN
    assign wrap_en = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign wrap_en     = 1'b0;
`endif

    // Stopped voices and fresh run edges both clear; the edge beats a same-cycle advance.
    always_comb begin
        ctx_d       = ctx_q;
        ctx_d.run_q = run;
        offset_inc  = ctx_q.offset + 24'd1;
        if (!run || !ctx_q.run_q) begin
            ctx_d.offset = '0;
            ctx_d.done   = 1'b0;
        end else if (advance) begin
            if (offset_inc == length) begin
                ctx_d.offset = '0;
                ctx_d.done   = !wrap_en;
            end else begin
                ctx_d.offset = offset_inc;
            end
        end else if (mark_done) begin
            ctx_d.done = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctx_q <= '0;
        end else begin
            ctx_q <= ctx_d;
        end
    end

    assign offset = ctx_q.offset;
    assign done   = ctx_q.done;
    assign active = run && !ctx_q.done && (length != '0);

endmodule

// File: rtl/sampler_dma_fetch_sequencer.sv
// Walks all voices on each sample tick, fetching one word per running voice and tagging it for the mixer.
// Optional loop playback is enabled with the SAMPLER_DMA_LOOP_EN macro.
module sampler_dma_fetch_sequencer
    import sampler_dma_pkg::*;
#(
    parameter int MAX_VOICES = 4,
    parameter int VOICE_W    = 2
)
(
    input  logic                         axi_clk,
    input  logic                         axi_reset,
    input  logic [MAX_VOICES-1:0][31:0]  dma_control,
    input  logic [MAX_VOICES-1:0][31:0]  dma_base_addr,
    input  logic                         sample_tick,
    output logic                         rd_req_valid,
    input  logic                         rd_req_ready,
    output logic [31:0]                  rd_req_addr,
    input  logic                         rd_rsp_valid,
    input  logic [31:0]                  rd_rsp_data,
    output logic                         smp_valid,
    input  logic                         smp_ready,
    output logic [VOICE_W-1:0]           smp_voice,
    output logic [31:0]                  smp_data,
    output logic [MAX_VOICES-1:0]        voice_done,
    output logic                         overrun
);

    localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(MAX_VOICES - 1);

    fetch_state_t          state_q, state_d;
    logic [VOICE_W-1:0]    voice_q, voice_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  overrun_q, overrun_d;
    logic [MAX_VOICES-1:0] active;
    logic [MAX_VOICES-1:0] advance;
    logic [MAX_VOICES-1:0] mark_done;
    logic [LEN_MSB:0]      offset [MAX_VOICES];

    for (genvar i = 0; i < MAX_VOICES; i++) begin : g_voice
        logic [5:0] unused_ctrl_bits;
        assign unused_ctrl_bits = dma_control[i][29:24];

        assign advance[i]   = (state_q == OUT) && smp_ready && (voice_q == VOICE_W'(i));
        assign mark_done[i] = (state_q == SCAN) && (voice_q == VOICE_W'(i))
                              && (dma_control[i][LEN_MSB:0] == '0);

        sampler_dma_voice_ctx u_ctx (
            .clk       (axi_clk),
            .reset     (axi_reset),
            .run       (dma_control[i][RUN_BIT]),
            .loop      (dma_control[i][LOOP_BIT]),
            .length    (dma_control[i][LEN_MSB:0]),
            .advance   (advance[i]),
            .mark_done (mark_done[i]),
            .offset    (offset[i]),
            .done      (voice_done[i]),
            .active    (active[i])
        );
    end

    // The address is latched on entry to ADDR so it cannot move while the request waits.
    always_comb begin
        state_d   = state_q;
        voice_d   = voice_q;
        addr_d    = addr_q;
        data_d    = data_q;
        overrun_d = overrun_q || (sample_tick && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = SCAN;
                    voice_d = '0;
                end
            end
            SCAN: begin
                if (active[voice_q]) begin
                    addr_d  = word_addr(dma_base_addr[voice_q], offset[voice_q]);
                    state_d = ADDR;
                end else if (voice_q == LAST_VOICE) begin
                    state_d = IDLE;
                end else begin
                    voice_d = voice_q + 1'b1;
                end
            end
            ADDR: begin
                if (rd_req_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (rd_rsp_valid) begin
                    data_d  = rd_rsp_data;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (smp_ready) begin
                    if (voice_q == LAST_VOICE) begin
                        state_d = IDLE;
                    end else begin
                        voice_d = voice_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q   <= IDLE;
            voice_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            voice_q   <= voice_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign rd_req_valid = (state_q == ADDR);
    assign rd_req_addr  = addr_q;
    assign smp_valid    = (state_q == OUT);
    assign smp_voice    = voice_q;
    assign smp_data     = data_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sampler_dma_fetch_sequencer.sv
// Self-checking bench for sampler_dma_fetch_sequencer against a pass-level playback model.
// Honours SAMPLER_DMA_LOOP_EN the same way the design does.
module tb_sampler_dma_fetch_sequencer;

    localparam int NV = 4;

`ifdef SAMPLER_DMA_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic                  axi_clk = 1'b0;
    logic                  axi_reset;
    logic [NV-1:0][31:0]   dma_control;
    logic [NV-1:0][31:0]   dma_base_addr;
    logic                  sample_tick;
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [31:0]           rd_req_addr;
    logic                  rd_rsp_valid;
    logic [31:0]           rd_rsp_data;
    logic                  smp_valid;
    logic                  smp_ready;
    logic [1:0]            smp_voice;
    logic [31:0]           smp_data;
    logic [NV-1:0]         voice_done;
    logic                  overrun;

    always #5 axi_clk = ~axi_clk;

    sampler_dma_fetch_sequencer #(.MAX_VOICES(NV), .VOICE_W(2)) dut (
        .axi_clk       (axi_clk),
        .axi_reset     (axi_reset),
        .dma_control   (dma_control),
        .dma_base_addr (dma_base_addr),
        .sample_tick   (sample_tick),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_data   (rd_rsp_data),
        .smp_valid     (smp_valid),
        .smp_ready     (smp_ready),
        .smp_voice     (smp_voice),
        .smp_data      (smp_data),
        .voice_done    (voice_done),
        .overrun       (overrun)
    );

    typedef struct {
        int          voice;
        logic [31:0] addr;
    } req_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned mOff [NV];
    bit          mDone [NV];
    bit          mPrevRun [NV];
    bit          expOverrun;
    req_t        expQ [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ctlWord(input bit run, input bit loop, input int len);
        return {run, loop, 6'd0, 24'(len)};
    endfunction

    function automatic logic [NV-1:0] modelDone();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = mDone[i];
        return v;
    endfunction

    // One tick's worth of playback: which words get fetched, then how each voice moves on.
    function automatic void buildPass();
        expQ.delete();
        for (int v = 0; v < NV; v++) begin
            bit          run  = dma_control[v][31];
            bit          loop = dma_control[v][30];
            int unsigned len  = dma_control[v][23:0];
            if (run && !mDone[v]) begin
                if (len == 0) begin
                    mDone[v] = 1'b1;
                end else begin
                    req_t r;
                    r.voice = v;
                    r.addr  = dma_base_addr[v] + 32'(mOff[v] * 4);
                    expQ.push_back(r);
                    if (mOff[v] + 1 == len) begin
                        mOff[v] = 0;
                        if (!(LOOP_EN && loop)) mDone[v] = 1'b1;
                    end else begin
                        mOff[v] = mOff[v] + 1;
                    end
                end
            end
        end
    endfunction

    // Register writes land while the sequencer is idle; stopping or restarting a voice rewinds it.
    task automatic applyStimulus(input logic [NV-1:0][31:0] ctl, input logic [NV-1:0][31:0] base);
        dma_control   = ctl;
        dma_base_addr = base;
        for (int v = 0; v < NV; v++) begin
            if (!ctl[v][31] || !mPrevRun[v]) begin
                mOff[v]  = 0;
                mDone[v] = 1'b0;
            end
            mPrevRun[v] = ctl[v][31];
        end
        repeat (2) @(negedge axi_clk);
    endtask

    task automatic pulseTick();
        sample_tick = 1'b1;
        @(negedge axi_clk);
        sample_tick = 1'b0;
    endtask

    task automatic servicePass(input int reqStall, input int smpStall, input bit injectTick);
        int   waited;
        int   stall;
        bit   stable;
        bit   sawReq;
        logic [31:0] data;
        buildPass();
        pulseTick();
        for (int i = 0; i < expQ.size(); i++) begin
            waited = 0;
            while (!rd_req_valid && waited < 40) begin
                @(negedge axi_clk);
                waited++;
            end
            if (!rd_req_valid) begin
                checkOutput("req_timeout", 32'd0, 32'd1);
                return;
            end
            if (i == 0) checkOutput("first_req_latency", 32'(waited), 32'(expQ[0].voice + 1));
            checkOutput("req_addr", rd_req_addr, expQ[i].addr);

            stall  = (reqStall < 0) ? int'($urandom_range(0, 5)) : reqStall;
            stable = 1'b1;
            repeat (stall) begin
                rd_rsp_valid = 1'($urandom_range(0, 1));
                rd_rsp_data  = $urandom;
                @(negedge axi_clk);
                rd_rsp_valid = 1'b0;
                if (rd_req_valid !== 1'b1 || rd_req_addr !== expQ[i].addr) stable = 1'b0;
            end
            checkOutput("req_stable", 32'(stable), 32'd1);
            rd_req_ready = 1'b1;
            @(negedge axi_clk);
            rd_req_ready = 1'b0;
            checkOutput("req_released", 32'(rd_req_valid), 32'd0);

            if (injectTick && i == 0) begin
                pulseTick();
                expOverrun = 1'b1;
            end
            repeat ($urandom_range(0, 3)) @(negedge axi_clk);
            data         = $urandom;
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = data;
            @(negedge axi_clk);
            rd_rsp_valid = 1'b0;
            rd_rsp_data  = $urandom;

            checkOutput("smp_valid", 32'(smp_valid), 32'd1);
            checkOutput("smp_voice", 32'(smp_voice), 32'(expQ[i].voice));
            checkOutput("smp_data", smp_data, data);
            stall  = (smpStall < 0) ? int'($urandom_range(0, 3)) : smpStall;
            stable = 1'b1;
            repeat (stall) begin
                rd_rsp_valid = 1'($urandom_range(0, 1));
                rd_rsp_data  = $urandom;
                @(negedge axi_clk);
                rd_rsp_valid = 1'b0;
                if (smp_valid !== 1'b1 || smp_data !== data || 32'(smp_voice) !== 32'(expQ[i].voice))
                    stable = 1'b0;
            end
            checkOutput("smp_stable", 32'(stable), 32'd1);
            smp_ready = 1'b1;
            @(negedge axi_clk);
            smp_ready = 1'b0;
            checkOutput("no_dup_sample", 32'(smp_valid), 32'd0);
        end
        sawReq = 1'b0;
        repeat (NV + 2) begin
            @(negedge axi_clk);
            if (rd_req_valid !== 1'b0) sawReq = 1'b1;
        end
        checkOutput("no_extra_req", 32'(sawReq), 32'd0);
        checkOutput("voice_done", 32'(voice_done), 32'(modelDone()));
        checkOutput("overrun", 32'(overrun), 32'(expOverrun));
    endtask

    initial begin
        logic [NV-1:0][31:0] ctl;
        logic [NV-1:0][31:0] base;
        int waited;

        axi_reset     = 1'b1;
        dma_control   = '0;
        dma_base_addr = '0;
        sample_tick   = 1'b0;
        rd_req_ready  = 1'b0;
        rd_rsp_valid  = 1'b0;
        rd_rsp_data   = '0;
        smp_ready     = 1'b0;
        expOverrun    = 1'b0;
        for (int v = 0; v < NV; v++) begin
            mOff[v] = 0; mDone[v] = 1'b0; mPrevRun[v] = 1'b0;
        end
        repeat (3) @(negedge axi_clk);
        axi_reset = 1'b0;
        @(negedge axi_clk);
        checkOutput("reset_req_valid", 32'(rd_req_valid), 32'd0);
        checkOutput("reset_smp_valid", 32'(smp_valid), 32'd0);
        checkOutput("reset_voice_done", 32'(voice_done), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_addr", rd_req_addr, 32'd0);

        $display("[TB] single voice, three words then done");
        ctl = '0; base = '0;
        ctl[0] = ctlWord(1, 0, 3); base[0] = 32'h0000_1000;
        applyStimulus(ctl, base);
        repeat (4) servicePass(0, 0, 1'b0);

        $display("[TB] voices 0 and 2 running");
        applyStimulus('0, base);
        ctl = '0; base = '0;
        ctl[0] = ctlWord(1, 0, 5); base[0] = 32'h0000_4000;
        ctl[2] = ctlWord(1, 0, 5); base[2] = 32'h0000_8000;
        applyStimulus(ctl, base);
        servicePass(0, 0, 1'b0);

        $display("[TB] back-pressure on request and sample");
        servicePass(5, 3, 1'b0);

        $display("[TB] tick during fetch");
        servicePass(0, 0, 1'b1);
        servicePass(-1, -1, 1'b0);

        $display("[TB] two-word voice with loop bit, address wrap");
        applyStimulus('0, base);
        ctl = '0; base = '0;
        ctl[1] = ctlWord(1, 1, 2); base[1] = 32'hFFFF_FFFC;
        applyStimulus(ctl, base);
        repeat (5) servicePass(0, 0, 1'b0);

        $display("[TB] randomized voice setups");
        for (int round = 0; round < 6; round++) begin
            for (int v = 0; v < NV; v++) begin
                ctl[v]  = ctlWord(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  int'($urandom_range(0, 4)));
                base[v] = $urandom;
            end
            applyStimulus(ctl, base);
            repeat (3) servicePass(-1, -1, 1'b0);
        end

        $display("[TB] reset during fetch");
        applyStimulus('0, base);
        ctl = '0; base = '0;
        ctl[0] = ctlWord(1, 0, 4); base[0] = 32'h0000_2000;
        applyStimulus(ctl, base);
        pulseTick();
        waited = 0;
        while (!rd_req_valid && waited < 40) begin
            @(negedge axi_clk);
            waited++;
        end
        checkOutput("rst_test_req_seen", 32'(rd_req_valid), 32'd1);
        rd_req_ready = 1'b1;
        @(negedge axi_clk);
        rd_req_ready = 1'b0;
        axi_reset = 1'b1;
        @(negedge axi_clk);
        axi_reset    = 1'b0;
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = 32'hDEAD_BEEF;
        @(negedge axi_clk);
        rd_rsp_valid = 1'b0;
        @(negedge axi_clk);
        checkOutput("rst_req_valid", 32'(rd_req_valid), 32'd0);
        checkOutput("rst_smp_valid", 32'(smp_valid), 32'd0);
        checkOutput("rst_smp_data", smp_data, 32'd0);
        checkOutput("rst_smp_voice", 32'(smp_voice), 32'd0);
        checkOutput("rst_addr", rd_req_addr, 32'd0);
        checkOutput("rst_voice_done", 32'(voice_done), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        expOverrun = 1'b0;
        for (int v = 0; v < NV; v++) begin
            mOff[v] = 0; mDone[v] = 1'b0; mPrevRun[v] = 1'b0;
        end
        applyStimulus('0, base);
        applyStimulus(ctl, base);
        servicePass(0, 0, 1'b0);
        servicePass(-1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
